// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with per-key press/release debounce.
// Tracks a single key at a time and reports press/release events as pulses.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic       R_clk_1000HZ,
  input  logic       I_rst_n,
  input  logic [3:0] I_col,
  output logic [3:0] O_row,
  output logic [3:0] O_key_code,
  output logic       O_key_valid,
  output logic       O_key_held,
  output logic       O_key_release,
  output logic [1:0] dbg_state
);

  // Event handshake: O_key_valid and O_key_release are single-cycle pulses with
  // no back-pressure; O_key_code is stable from the valid pulse until the next
  // accepted press, and O_key_held is high from press to release acceptance.

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CNT - 1);

  state_t     state, state_n;
  logic [3:0] col_m, col_s;
  logic [1:0] row_idx, row_n;
  logic [1:0] phase, phase_n;
  logic [1:0] col_idx, col_idx_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] code_n;
  logic       valid_n, held_n, release_n;
  logic [1:0] low_idx;
  logic       key_low;

  always_ff @(posedge R_clk_1000HZ or negedge I_rst_n) begin
    if (!I_rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= I_col;
      col_s <= col_m;
    end
  end

  // Lowest-numbered low column wins when several keys share the row.
  always_comb begin
    low_idx = 2'd3;
    if (!col_s[0])      low_idx = 2'd0;
    else if (!col_s[1]) low_idx = 2'd1;
    else if (!col_s[2]) low_idx = 2'd2;
  end

  assign key_low = ~col_s[col_idx];

  always_comb begin
    state_n   = state;
    row_n     = row_idx;
    phase_n   = phase;
    col_idx_n = col_idx;
    cnt_n     = cnt;
    code_n    = O_key_code;
    valid_n   = 1'b0;
    held_n    = O_key_held;
    release_n = 1'b0;
    case (state)
      SCAN: begin
        phase_n = phase + 2'd1;
        if (phase == 2'd3) begin
          if (col_s == 4'hF) begin
            row_n = row_idx + 2'd1;
          end else begin
            col_idx_n = low_idx;
            state_n   = DB_PRESS;
            cnt_n     = 8'd1;
          end
        end
      end
      DB_PRESS: begin
        if (key_low) begin
          if (cnt >= CNT_LAST) begin
            state_n = HELD;
            cnt_n   = 8'd0;
            code_n  = {row_idx, col_idx};
            valid_n = 1'b1;
            held_n  = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          state_n = SCAN;
          row_n   = row_idx + 2'd1;
          phase_n = 2'd0;
          cnt_n   = 8'd0;
        end
      end
      HELD: begin
        if (!key_low) begin
          state_n = DB_RELEASE;
          cnt_n   = 8'd1;
        end
      end
      DB_RELEASE: begin
        if (!key_low) begin
          if (cnt >= CNT_LAST) begin
            state_n   = SCAN;
            row_n     = row_idx + 2'd1;
            phase_n   = 2'd0;
            cnt_n     = 8'd0;
            held_n    = 1'b0;
            release_n = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          // Short release glitch: back to holding without any event.
          state_n = HELD;
          cnt_n   = 8'd0;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge R_clk_1000HZ or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= SCAN;
      row_idx       <= 2'd0;
      phase         <= 2'd0;
      col_idx       <= 2'd0;
      cnt           <= 8'd0;
      O_row         <= 4'b1110;
      O_key_code    <= 4'd0;
      O_key_valid   <= 1'b0;
      O_key_held    <= 1'b0;
      O_key_release <= 1'b0;
    end else begin
      state         <= state_n;
      row_idx       <= row_n;
      phase         <= phase_n;
      col_idx       <= col_idx_n;
      cnt           <= cnt_n;
      O_row         <= ~(4'b0001 << row_n);
      O_key_code    <= code_n;
      O_key_valid   <= valid_n;
      O_key_held    <= held_n;
      O_key_release <= release_n;
    end
  end

  assign dbg_state = state;

endmodule
